// File: rtl/mux_data.sv
// Registered 4:1 lane-select multiplexer; REG_OUT=0 gives a purely combinational path.
// Optional macro MUXDATA_SEL_FILTER_EN debounces {s1,s0} (registered build only).
module mux_data #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] out
);

    // Only the selected lane is forwarded, so X on unselected lanes cannot leak through.
    function automatic logic [WIDTH-1:0] lane_pick(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] in_a,
        input logic [WIDTH-1:0] in_b,
        input logic [WIDTH-1:0] in_c,
        input logic [WIDTH-1:0] in_d
    );
        logic [WIDTH-1:0] res;
        case (sel)
            2'b00:   res = in_a;
            2'b01:   res = in_b;
            2'b10:   res = in_c;
            2'b11:   res = in_d;
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    logic [1:0]       w_sel_raw;
    logic [1:0]       w_sel_use;
    logic [WIDTH-1:0] w_mux;

    assign w_sel_raw = {s1, s0};

    generate
        if (REG_OUT) begin : g_reg
`ifdef MUXDATA_SEL_FILTER_EN
            logic [1:0] r_sel_prev;
            logic [1:0] r_sel_q;

            // Select is accepted only after it matches on two consecutive edges.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sel_prev <= 2'b00;
                    r_sel_q    <= 2'b00;
                end else begin
                    r_sel_prev <= w_sel_raw;
                    if (w_sel_raw == r_sel_prev) begin
                        r_sel_q <= w_sel_raw;
                    end else begin
                        r_sel_q <= r_sel_q;
                    end
                end
            end

            assign w_sel_use = r_sel_q;
`else
            assign w_sel_use = w_sel_raw;
`endif
            logic [WIDTH-1:0] r_out;

            // Single output stage; reset clears it without waiting for a clock.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= {WIDTH{1'b0}};
                end else begin
                    r_out <= w_mux;
                end
            end

            assign out = r_out;
        end else begin : g_comb
            assign w_sel_use = w_sel_raw;
            assign out       = w_mux;
        end
    endgenerate

    // Lane selection shared by both output styles.
    always_comb begin
        w_mux = lane_pick(w_sel_use, a, b, c, d);
    end

endmodule

// File: tb/tb_mux_data.sv
// Directed self-checking bench for mux_data: registered 1-bit instance plus a combinational 8-bit instance.
module tb_mux_data;

    logic       clk;
    logic       rst;
    logic       a, b, c, d, s0, s1;
    logic       out;

    logic [7:0] ca, cb, cc, cd, cout;
    logic       cs0, cs1;

    int n_total;
    int n_bad;

    mux_data #(.WIDTH(1), .REG_OUT(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d),
        .s0(s0), .s1(s1),
        .out(out)
    );

    mux_data #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst(rst),
        .a(ca), .b(cb), .c(cc), .d(cd),
        .s0(cs0), .s1(cs1),
        .out(cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] s);
        {s1, s0} = s;
    endtask

    initial begin
        logic [3:0] onehot;
        logic [3:0] sweep_exp;
        n_total = 0;
        n_bad   = 0;
        ca = 8'h00; cb = 8'h00; cc = 8'h00; cd = 8'h00;
        cs0 = 1'b0; cs1 = 1'b0;

        // Reset: all inputs 1, output forced to 0 immediately and while held
        rst = 1'b1;
        a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1;
        set_sel(2'b00);
        #3;
        chk("rst_async", {63'd0, out}, 64'd0);
        tick();
        chk("rst_hold1", {63'd0, out}, 64'd0);
        tick();
        chk("rst_hold2", {63'd0, out}, 64'd0);
        rst = 1'b0;
        chk("rst_rel_noclk", {63'd0, out}, 64'd0);
        tick();
        chk("rst_rel_first", {63'd0, out}, 64'd1);

`ifndef MUXDATA_SEL_FILTER_EN
        // Select 00 passes a
        a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b0;
        tick();
        chk("sel00_a1", {63'd0, out}, 64'd1);
        a = 1'b0; b = 1'b1;
        #1;
        chk("sel00_lat", {63'd0, out}, 64'd1);
        tick();
        chk("sel00_a0", {63'd0, out}, 64'd0);

        // Sweep all selects over a=0 b=1 c=0 d=1
        a = 1'b0; b = 1'b1; c = 1'b0; d = 1'b1;
        sweep_exp = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            set_sel(i[1:0]);
            tick();
            chk($sformatf("sweep%0d", i), {63'd0, out}, {63'd0, sweep_exp[i]});
        end

        // One-hot data walk at sel=00 then sel=11
        set_sel(2'b00);
        for (int i = 0; i < 4; i++) begin
            onehot = 4'b0001 << i;
            {d, c, b, a} = onehot;
            tick();
            chk($sformatf("walk00_%0d", i), {63'd0, out}, (i == 0) ? 64'd1 : 64'd0);
        end
        set_sel(2'b11);
        for (int i = 0; i < 4; i++) begin
            onehot = 4'b0001 << i;
            {d, c, b, a} = onehot;
            tick();
            chk($sformatf("walk11_%0d", i), {63'd0, out}, (i == 3) ? 64'd1 : 64'd0);
        end

        // Simultaneous select and data change land together
        set_sel(2'b01);
        a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
        tick();
        set_sel(2'b10);
        b = 1'b1; c = 1'b0;
        tick();
        chk("simul_change", {63'd0, out}, 64'd0);

        // Mid-run reset pulse between edges
        set_sel(2'b10);
        a = 1'b0; b = 1'b0; c = 1'b1; d = 1'b0;
        tick();
        chk("mid_pre", {63'd0, out}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async", {63'd0, out}, 64'd0);
        #3;
        rst = 1'b0;
        chk("mid_held_edge", {63'd0, out}, 64'd0);
        tick();
        chk("mid_release", {63'd0, out}, 64'd1);
`else
        // Debounce: one-cycle glitch to 11 is ignored
        a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b1;
        set_sel(2'b00);
        tick();
        tick();
        chk("flt_base", {63'd0, out}, 64'd0);
        set_sel(2'b11);
        tick();
        set_sel(2'b00);
        tick();
        chk("flt_glitch1", {63'd0, out}, 64'd0);
        tick();
        chk("flt_glitch2", {63'd0, out}, 64'd0);
        // Stable select reaches out two clocks after it is seen stable
        set_sel(2'b11);
        tick();
        chk("flt_hold1", {63'd0, out}, 64'd0);
        tick();
        chk("flt_hold2", {63'd0, out}, 64'd0);
        tick();
        chk("flt_hold3", {63'd0, out}, 64'd1);
`endif

        // Combinational instance: X on unselected lanes must not leak, rst has no effect
        rst = 1'b1;
        ca = 8'hA5; cb = 8'hxx; cc = 8'hxx; cd = 8'hxx;
        {cs1, cs0} = 2'b00;
        #1;
        chk("comb_a", {56'd0, cout}, 64'h0000_0000_0000_00A5);
        ca = 8'hxx; cb = 8'h3C;
        {cs1, cs0} = 2'b01;
        #1;
        chk("comb_b", {56'd0, cout}, 64'h0000_0000_0000_003C);
        cb = 8'hxx; cc = 8'hF0;
        {cs1, cs0} = 2'b10;
        #1;
        chk("comb_c", {56'd0, cout}, 64'h0000_0000_0000_00F0);
        rst = 1'b0;
        cc = 8'hxx; cd = 8'h81;
        {cs1, cs0} = 2'b11;
        #1;
        chk("comb_d", {56'd0, cout}, 64'h0000_0000_0000_0081);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
